bch_syndrome_ctrl: RTL

- Bit-serial front-end sequencer directly upstream of the BCH syndrome stage.
- Accepts codeword bits over a valid/ready handshake and counts codeword boundaries.
- Drives the syndrome stage's start / syn_ce / din / shuffle_ce strobes.
- Presents a completed-syndrome valid/ready handshake, plus an error-present flag, to the downstream error-locator stage.

---
 rtl/bch_syndrome_ctrl_if.sv | 68 ++++++
 rtl/bch_syndrome_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bch_syndrome_ctrl_if.sv
// ---------------------------------------------------------------------------
// bch_syndrome_ctrl_if
//
// Bundles every non-clock signal of bch_syndrome_ctrl.
//
// Handshake semantics, used by both handshakes in this bundle:
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. valid may not depend on ready. Once raised, valid holds its value
//   (and its payload) until the transfer. ready may rise and fall freely.
//   Upstream codeword bits use data_valid/data_ready (payload data_in).
//   Completed syndromes use syn_valid/syn_ready. The syn_valid handoff is
//   taken by the first bit of the next codeword, not by a separate edge.
//
// Signals (direction seen from the slave, which is the controller):
//   data_in      in   serial codeword bit, first bit first
//   data_valid   in   data_in is valid this cycle
//   data_ready   out  controller accepts data_in this cycle
//   syn_in       in   syndromes 1..2T-1 read back from the syndrome stage
//   shuffle_req  in   downstream asks for one syndrome rotate cycle
//   start        out  first bit of a codeword to the syndrome stage
//   syn_ce       out  subsequent bit to the syndrome stage
//   din          out  bit to the syndrome stage
//   shuffle_ce   out  shuffle strobe to the syndrome stage
//   syn_valid    out  held syndromes are final and not yet handed off
//   syn_ready    in   downstream can take a new syndrome set
//   err_present  out  held syndromes are nonzero
//   busy         out  a codeword is partially received
//   dbg_state    out  FSM state (0 = IDLE, 1 = RECV)
//   dbg_cnt      out  bit counter
// ---------------------------------------------------------------------------
interface bch_syndrome_ctrl_if #(
  parameter int M = 4,
  parameter int T = 3,
  parameter int N = 15
);
  localparam int SYN_W = (2 * T - 1) * M;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  logic             data_in;
  logic             data_valid;
  logic             data_ready;
  logic [SYN_W-1:0] syn_in;
  logic             shuffle_req;
  logic             start;
  logic             syn_ce;
  logic             din;
  logic             shuffle_ce;
  logic             syn_valid;
  logic             syn_ready;
  logic             err_present;
  logic             busy;
  logic             dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  // Controller side.
  modport slave (
    input  data_in, data_valid, syn_in, shuffle_req, syn_ready,
    output data_ready, start, syn_ce, din, shuffle_ce, syn_valid,
           err_present, busy, dbg_state, dbg_cnt
  );

  // Environment side: codeword source, syndrome stage and error locator.
  modport master (
    output data_in, data_valid, syn_in, shuffle_req, syn_ready,
    input  data_ready, start, syn_ce, din, shuffle_ce, syn_valid,
           err_present, busy, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/bch_syndrome_ctrl.sv
// ---------------------------------------------------------------------------
// bch_syndrome_ctrl
//
// Bit-serial front-end sequencer for a BCH syndrome stage. It accepts
// codeword bits over data_valid/data_ready and counts N bits per codeword.
// It drives start (first bit) or syn_ce (later bits) together with din, in
// the same cycle the bit is accepted. After the last bit it raises
// syn_valid toward the error locator.
//
// The syndrome stage holds the finished syndromes until the next start
// reloads them. So the first bit of the next codeword is the handoff point.
// In that cycle shuffle_ce copies the old syndromes into the stage's shuffle
// register, and syn_valid drops. While a finished set is unclaimed
// (syn_valid && !syn_ready), the first bit of the next codeword is held off.
//
// Parameters:
//   M  field order / syndrome element width
//   T  correctable errors; syn_in carries 2*T-1 elements
//   N  codeword length in bits, legal range 2..2^M-1
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards any partial codeword
//   bus    bch_syndrome_ctrl_if.slave (see the interface for the signals)
// ---------------------------------------------------------------------------
module bch_syndrome_ctrl #(
  parameter int M = 4,
  parameter int T = 3,
  parameter int N = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  bch_syndrome_ctrl_if.slave    bus
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             syn_valid_q, syn_valid_d;

  logic             data_ready_w;
  logic             start_w;
  logic             syn_ce_w;
  logic             shuffle_ce_w;
  logic             acc;
  logic             syn_set;
  logic             syn_clr;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      syn_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      syn_valid_q <= syn_valid_d;
    end
  end

  // Accept event. data_ready_w already carries the reset gating.
  assign acc = bus.data_valid && data_ready_w;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    syn_valid_d = syn_valid_q;
    syn_set     = 1'b0;
    syn_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc) begin
          // First bit. If a finished set is still pending, this is its handoff.
          state_d = RECV;
          cnt_d   = ONE;
          syn_clr = syn_valid_q;
        end
      end
      RECV: begin
        if (acc) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            syn_set = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Set wins over clear. They cannot coincide while N >= 2, because
    // set happens only in RECV and clear only in IDLE.
    if (syn_set) begin
      syn_valid_d = 1'b1;
    end else if (syn_clr) begin
      syn_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic. Strobes are combinational, so the syndrome stage sees each
  // bit in the cycle it is accepted. Reset forces all of them low.
  // -------------------------------------------------------------------------
  always_comb begin
    data_ready_w = 1'b0;
    start_w      = 1'b0;
    syn_ce_w     = 1'b0;
    shuffle_ce_w = 1'b0;

    if (!reset) begin
      if (state_q == RECV) begin
        data_ready_w = 1'b1;
      end else begin
        data_ready_w = !syn_valid_q || bus.syn_ready;
      end

      start_w  = bus.data_valid && data_ready_w && (state_q == IDLE);
      syn_ce_w = bus.data_valid && data_ready_w && (state_q == RECV);

      // A start that performs a handoff always shuffles. Any other start
      // overrides shuffle_req, because start rewrites the syndrome registers.
      shuffle_ce_w = (start_w && syn_valid_q) || (bus.shuffle_req && !start_w);
    end
  end

  assign bus.data_ready  = data_ready_w;
  assign bus.start       = start_w;
  assign bus.syn_ce      = syn_ce_w;
  assign bus.din         = bus.data_in;
  assign bus.shuffle_ce  = shuffle_ce_w;
  assign bus.syn_valid   = syn_valid_q;
  // syn_ce is low in IDLE, so syn_in is stable for as long as syn_valid is high.
  assign bus.err_present = syn_valid_q && (|bus.syn_in);
  assign bus.busy        = (state_q == RECV);
  assign bus.dbg_state   = state_q;
  assign bus.dbg_cnt     = cnt_q;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
    !(start_w && syn_ce_w));

  a_cnt_range: assert property (@(posedge clk) disable iff (reset)
    cnt_q <= LAST);

  a_idle_cnt_zero: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> (cnt_q == '0));

endmodule
